// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants and helpers for the pipelined adder
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: at least one stage, no more stages than bits, equal chunks.
  function automatic bit widths_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// rtl/pipe_add_stage.sv - combinational CW-bit ripple chunk adder
module pipe_add_stage #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          cmsb
);

  logic carry;
  logic cm;

  // Ripple through one full-adder cell per bit; remember the carry entering the MSB.
  always_comb begin
    carry = ci;
    cm    = 1'b0;
    s     = '0;
    for (int i = 0; i < CW; i++) begin
      s[i] = a[i] ^ b[i] ^ carry;
      if (i == CW - 1) cm = carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co   = carry;
    cmsb = cm;
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined add/subtract unit with valid/ready handshake
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW     = chunk_width(WIDTH, STAGES);
  localparam bit CFG_OK = widths_ok(WIDTH, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
  end

  // Per-stage registers: valid, skewed operands, partial sum and chunk carry.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic                         ovf_q;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [STAGES-1:0][CW-1:0] op_a;
  logic [STAGES-1:0][CW-1:0] op_b;
  logic [STAGES-1:0][CW-1:0] st_s;
  logic [STAGES-1:0]         op_c;
  logic [STAGES-1:0]         st_co;
  logic [STAGES-1:0]         st_cm;

  // The whole pipe moves together whenever the output slot is free or being drained.
  assign adv       = !v_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Stage 0 works on the live inputs; stage k works on chunk k of the operands skewed down from stage k-1.
  always_comb begin
    op_a    = '0;
    op_b    = '0;
    op_c    = '0;
    b_eff   = (sub == MODE_SUB) ? ~b : b;
    cin_eff = (sub == MODE_SUB) ? 1'b1 : cin;
    op_a[0] = a[CW-1:0];
    op_b[0] = b_eff[CW-1:0];
    op_c[0] = cin_eff;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1][k*CW +: CW];
      op_b[k] = b_q[k-1][k*CW +: CW];
      op_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_add_stage #(.CW(CW)) u_stage (
      .a    (op_a[k]),
      .b    (op_b[k]),
      .ci   (op_c[k]),
      .s    (st_s[k]),
      .co   (st_co[k]),
      .cmsb (st_cm[k])
    );
  end

  // Shift every stage one position on advance; hold everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0]          <= in_valid;
      a_q[0]          <= a;
      b_q[0]          <= b_eff;
      s_q[0]          <= '0;
      s_q[0][CW-1:0]  <= st_s[0];
      c_q[0]          <= st_co[0];
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]              <= v_q[k-1];
        a_q[k]              <= a_q[k-1];
        b_q[k]              <= b_q[k-1];
        s_q[k]              <= s_q[k-1];
        s_q[k][k*CW +: CW]  <= st_s[k];
        c_q[k]              <= st_co[k];
      end
      ovf_q <= st_cm[STAGES-1] ^ st_co[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder at 4, 1 and 16 stages
module tb_pipe_adder;

  localparam int W  = 16;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv[ND], ir[ND], ov[ND], ordy[ND], cin_s[ND], sub_s[ND], co[ND], of[ND];
  logic [W-1:0] a_s[ND], b_s[ND], sum_s[ND];

  int checks = 0;
  int failures = 0;

  logic [17:0] q[ND][$];
  logic [17:0] hold_v[ND];
  bit          hold_pend[ND];

  pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .cin(cin_s[0]), .sub(sub_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_s[0]), .cout(co[0]), .ovf(of[0]));

  pipe_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .cin(cin_s[1]), .sub(sub_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum_s[1]), .cout(co[1]), .ovf(of[1]));

  pipe_adder #(.WIDTH(W), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]), .b(b_s[2]),
    .cin(cin_s[2]), .sub(sub_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sum_s[2]), .cout(co[2]), .ovf(of[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the operand values, packed as {cout, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic su);
    int r;
    logic c;
    logic [15:0] s;
    if (su) begin
      r = int'($signed(a)) - int'($signed(b));
      c = (a >= b);
      s = 16'(int'(a) - int'(b));
    end else begin
      r = int'($signed(a)) + int'($signed(b)) + int'(ci);
      c = (int'(a) + int'(b) + int'(ci)) > 65535;
      s = 16'(int'(a) + int'(b) + int'(ci));
    end
    return {c, (r > 32767) || (r < -32768), s};
  endfunction

  function automatic logic [17:0] outv(input int d);
    return {co[d], of[d], sum_s[d]};
  endfunction

  task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic su, input logic [17:0] exp);
    int lat;
    iv[0] = 1'b1; a_s[0] = a; b_s[0] = b; cin_s[0] = ci; sub_s[0] = su; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0; a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); cin_s[0] = ~ci; sub_s[0] = ~su;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " result"}, outv(0), exp);
    @(negedge clk);
  endtask

  logic [15:0] va[8], vb[8];
  logic        vc[8], vs[8];
  logic [17:0] vexp[8];
  logic [17:0] held;
  int          n_in, n_out, stall;
  bit          seen, any_ov;

  initial begin
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; a_s[d] = '0; b_s[d] = '0; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
      hold_pend[d] = 1'b0; hold_v[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d reset out_valid", d), ov[d], 0);
      chk($sformatf("d%0d reset result", d), outv(d), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run1("add basic",    16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
    run1("add carry",    16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
    run1("add overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    run1("sub borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run1("sub overflow", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

    // Back-pressure: 8 beats back-to-back, 3-cycle stall once the first result shows.
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom); vs[i] = 1'($urandom);
      vexp[i] = model(va[i], vb[i], vc[i], vs[i]);
    end
    n_in = 0; n_out = 0; stall = 0; seen = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      iv[0] = (n_in < 8);
      if (n_in < 8) begin
        a_s[0] = va[n_in]; b_s[0] = vb[n_in]; cin_s[0] = vc[n_in]; sub_s[0] = vs[n_in];
      end
      if (ov[0] && !seen) begin
        seen = 1'b1; stall = 3; held = outv(0);
      end
      ordy[0] = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("stall in_ready", ir[0], 0);
        if (stall < 3) begin
          chk("stall out_valid", ov[0], 1);
          chk("stall hold", outv(0), held);
        end
        stall--;
      end
      if (ov[0] && ordy[0]) begin
        chk($sformatf("bp result %0d", n_out), outv(0), vexp[n_out]);
        chk($sformatf("bp cycle %0d", n_out), cyc, 7 + n_out);
        n_out++;
      end
      if (iv[0] && ir[0]) n_in++;
      @(negedge clk);
    end
    chk("bp count", n_out, 8);
    iv[0] = 1'b0; ordy[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Bubbles then reset with two beats in flight.
    iv[0] = 1'b1; a_s[0] = 16'h1111; b_s[0] = 16'h2222; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b1; a_s[0] = 16'h0F0F; b_s[0] = 16'h0101;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("pre-reset out_valid", ov[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", ov[0], 0);
    chk("async reset result", outv(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) any_ov = 1'b1;
    end
    chk("no stale beat after reset", any_ov, 0);
    run1("post-reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});

    // Random traffic on all three depths with random valid/ready.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int d = 0; d < ND; d++) begin
        if (hold_pend[d]) begin
          chk($sformatf("d%0d hold valid", d), ov[d], 1);
          chk($sformatf("d%0d hold data", d), outv(d), hold_v[d]);
        end
        iv[d] = ($urandom_range(0, 3) != 0);
        ordy[d] = ($urandom_range(0, 3) != 0);
        a_s[d] = 16'($urandom); b_s[d] = 16'($urandom);
        cin_s[d] = 1'($urandom); sub_s[d] = 1'($urandom);
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("d%0d in_ready", d), ir[d], !ov[d] || ordy[d]);
        if (ov[d] && ordy[d]) begin
          chk($sformatf("d%0d out beat expected", d), 32'(q[d].size() != 0), 1);
          if (q[d].size() != 0) chk($sformatf("d%0d random result", d), outv(d), q[d].pop_front());
        end
        if (iv[d] && ir[d]) q[d].push_back(model(a_s[d], b_s[d], cin_s[d], sub_s[d]));
        hold_pend[d] = ov[d] && !ordy[d];
        hold_v[d] = outv(d);
      end
      @(negedge clk);
    end

    // Drain what is still in flight.
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int d = 0; d < ND; d++) begin
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        if (ov[d]) begin
          chk($sformatf("d%0d drain beat expected", d), 32'(q[d].size() != 0), 1);
          if (q[d].size() != 0) chk($sformatf("d%0d drain result", d), outv(d), q[d].pop_front());
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < ND; d++) chk($sformatf("d%0d all beats emerged", d), q[d].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
